// File: rtl/sb_msg_frame_agent.sv
// rtl/sb_msg_frame_agent.sv - sideband message agent: TX frame serializer and RX frame deserializer/checker
module sb_msg_frame_agent #(
    parameter int         GAP_CYCLES = 2,
    parameter logic [3:0] PREAMBLE   = 4'hA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [3:0] i_sideband_message,
    input  logic [2:0] i_sideband_data_lanes_encoding,
    output logic       o_busy,
    output logic       o_falling_edge_busy,
    output logic       o_sb_data,
    output logic       o_sb_valid,
    input  logic       i_sb_data,
    input  logic       i_sb_valid,
    output logic [3:0] o_rx_msg,
    output logic [2:0] o_rx_lanes,
    output logic       o_rx_msg_valid,
    output logic       o_rx_err
);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_GAP,
        TX_DONE
    } tx_state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES);

    tx_state_t   tx_state_q;
    logic        arm_q;
    logic [14:0] tx_sh_q;
    logic [3:0]  tx_cnt_q;
    logic        busy_q;
    logic        feb_q;
    logic        sb_data_q;
    logic        sb_valid_q;
    logic [15:0] tx_frame_d;

    logic [14:0] rx_sh_q;
    logic [3:0]  rx_cnt_q;
    logic [3:0]  rx_msg_q;
    logic [2:0]  rx_lanes_q;
    logic        rx_msg_valid_q;
    logic        rx_err_q;
    logic [15:0] rx_frame_d;
    logic        rx_good_d;

    // Parity covers message and lanes only; the reserved field is zero by construction.
    assign tx_frame_d = {PREAMBLE, i_sideband_message, i_sideband_data_lanes_encoding,
                         4'b0000, ^{i_sideband_message, i_sideband_data_lanes_encoding}};

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            arm_q      <= 1'b1;
            tx_sh_q    <= '0;
            tx_cnt_q   <= '0;
            busy_q     <= 1'b0;
            feb_q      <= 1'b0;
            sb_data_q  <= 1'b0;
            sb_valid_q <= 1'b0;
        end else begin
            feb_q <= 1'b0;
            if (!i_valid) begin
                arm_q <= 1'b1;
            end
            case (tx_state_q)
                TX_IDLE: begin
                    if (i_valid && arm_q && (i_sideband_message != 4'h0)) begin
                        arm_q      <= 1'b0;
                        tx_state_q <= TX_SEND;
                        busy_q     <= 1'b1;
                        sb_valid_q <= 1'b1;
                        sb_data_q  <= tx_frame_d[15];
                        tx_sh_q    <= tx_frame_d[14:0];
                        tx_cnt_q   <= 4'd0;
                    end
                end
                TX_SEND: begin
                    if (tx_cnt_q == 4'd15) begin
                        sb_valid_q <= 1'b0;
                        sb_data_q  <= 1'b0;
                        if (GAP_LAST != 4'd0) begin
                            tx_state_q <= TX_GAP;
                            tx_cnt_q   <= 4'd1;
                        end else begin
                            tx_state_q <= TX_DONE;
                            tx_cnt_q   <= 4'd0;
                            busy_q     <= 1'b0;
                            feb_q      <= 1'b1;
                        end
                    end else begin
                        sb_data_q <= tx_sh_q[14];
                        tx_sh_q   <= {tx_sh_q[13:0], 1'b0};
                        tx_cnt_q  <= tx_cnt_q + 4'd1;
                    end
                end
                TX_GAP: begin
                    if (tx_cnt_q == GAP_LAST) begin
                        tx_state_q <= TX_DONE;
                        tx_cnt_q   <= 4'd0;
                        busy_q     <= 1'b0;
                        feb_q      <= 1'b1;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 4'd1;
                    end
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign rx_frame_d = {rx_sh_q, i_sb_data};
    assign rx_good_d  = (rx_frame_d[15:12] == PREAMBLE) && (rx_frame_d[4:1] == 4'b0000)
                        && !(^rx_frame_d[11:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sh_q        <= '0;
            rx_cnt_q       <= '0;
            rx_msg_q       <= '0;
            rx_lanes_q     <= '0;
            rx_msg_valid_q <= 1'b0;
            rx_err_q       <= 1'b0;
        end else begin
            rx_msg_valid_q <= 1'b0;
            rx_err_q       <= 1'b0;
            if (i_sb_valid) begin
                rx_sh_q <= rx_frame_d[14:0];
                if (rx_cnt_q == 4'd15) begin
                    rx_cnt_q <= 4'd0;
                    if (rx_good_d) begin
                        rx_msg_q       <= rx_frame_d[11:8];
                        rx_lanes_q     <= rx_frame_d[7:5];
                        rx_msg_valid_q <= 1'b1;
                    end else begin
                        rx_err_q <= 1'b1;
                    end
                end else begin
                    rx_cnt_q <= rx_cnt_q + 4'd1;
                end
            end else if (rx_cnt_q != 4'd0) begin
                // Valid dropped mid-frame: the partial frame is discarded.
                rx_cnt_q <= 4'd0;
                rx_err_q <= 1'b1;
            end
        end
    end

    assign o_busy              = busy_q;
    assign o_falling_edge_busy = feb_q;
    assign o_sb_data           = sb_data_q;
    assign o_sb_valid          = sb_valid_q;
    assign o_rx_msg            = rx_msg_q;
    assign o_rx_lanes          = rx_lanes_q;
    assign o_rx_msg_valid      = rx_msg_valid_q;
    assign o_rx_err            = rx_err_q;

endmodule

// File: tb/tb_sb_msg_frame_agent.sv
// tb/tb_sb_msg_frame_agent.sv - scoreboard bench for sb_msg_frame_agent
module tb_sb_msg_frame_agent;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_valid = 1'b0;
    logic [3:0] i_sideband_message = 4'h0;
    logic [2:0] i_sideband_data_lanes_encoding = 3'd0;
    logic       o_busy;
    logic       o_falling_edge_busy;
    logic       o_sb_data;
    logic       o_sb_valid;
    logic       i_sb_data = 1'b0;
    logic       i_sb_valid = 1'b0;
    logic [3:0] o_rx_msg;
    logic [2:0] o_rx_lanes;
    logic       o_rx_msg_valid;
    logic       o_rx_err;

    sb_msg_frame_agent #(.GAP_CYCLES(2), .PREAMBLE(4'hA)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .i_valid                        (i_valid),
        .i_sideband_message             (i_sideband_message),
        .i_sideband_data_lanes_encoding (i_sideband_data_lanes_encoding),
        .o_busy                         (o_busy),
        .o_falling_edge_busy            (o_falling_edge_busy),
        .o_sb_data                      (o_sb_data),
        .o_sb_valid                     (o_sb_valid),
        .i_sb_data                      (i_sb_data),
        .i_sb_valid                     (i_sb_valid),
        .o_rx_msg                       (o_rx_msg),
        .o_rx_lanes                     (o_rx_lanes),
        .o_rx_msg_valid                 (o_rx_msg_valid),
        .o_rx_err                       (o_rx_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int feb_seen = 0;
    int exp_feb = 0;

    logic [15:0] txq_frame[$];
    int          txq_start[$];
    logic [7:0]  rxq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [15:0] f, input int start);
        txq_frame.push_back(f);
        txq_start.push_back(start);
        exp_feb++;
    endtask

    task automatic rx_bits(input logic [15:0] f, input int n);
        logic [15:0] v;
        v = f;
        for (int i = 15; i > 15 - n; i--) begin
            i_sb_valid = 1'b1;
            i_sb_data  = v[i];
            tick();
        end
    endtask

    task automatic rx_idle();
        i_sb_valid = 1'b0;
        i_sb_data  = 1'b0;
    endtask

    // Monitor: collects TX frames and RX events, pops the scoreboard queues
    initial begin
        logic [15:0] sh;
        logic [15:0] ef;
        logic [7:0]  er;
        int          n;
        int          st;
        int          es;
        sh = '0;
        n  = 0;
        st = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                n = 0;
            end else begin
                if (o_falling_edge_busy) feb_seen++;
                if (!o_sb_valid) check("sb_data_when_invalid", o_sb_data, 0);
                if (o_sb_valid) begin
                    if (n == 0) st = cyc;
                    sh = {sh[14:0], o_sb_data};
                    n++;
                    if (n == 16) begin
                        n = 0;
                        if (txq_frame.size() == 0) begin
                            check("tx_unexpected_frame", txq_frame.size(), 1);
                        end else begin
                            ef = txq_frame.pop_front();
                            es = txq_start.pop_front();
                            check("tx_frame", sh, ef);
                            check("tx_start_cycle", st, es);
                        end
                    end
                end
                if (o_rx_msg_valid || o_rx_err) begin
                    check("rx_valid_err_exclusive", o_rx_msg_valid & o_rx_err, 0);
                    if (rxq.size() == 0) begin
                        check("rx_unexpected_event", rxq.size(), 1);
                    end else begin
                        er = rxq.pop_front();
                        check("rx_event", {o_rx_err, o_rx_msg, o_rx_lanes}, er);
                    end
                end
            end
        end
    end

    initial begin
        int t;
        logic [15:0] f6;

        repeat (3) tick();
        check("rst_busy", o_busy, 0);
        check("rst_feb", o_falling_edge_busy, 0);
        check("rst_sb_valid", o_sb_valid, 0);
        check("rst_rx_msg", o_rx_msg, 0);
        check("rst_rx_lanes", o_rx_lanes, 0);
        check("rst_rx_flags", {o_rx_msg_valid, o_rx_err}, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Single frame A560: busy T+1..T+18, falling-edge strobe at T+19
        t = cyc;
        i_valid = 1'b1;
        i_sideband_message = 4'h5;
        i_sideband_data_lanes_encoding = 3'b011;
        push_tx(16'hA560, t + 1);
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 1) i_valid = 1'b0;
            check("t1_busy", o_busy, (k <= 18) ? 1 : 0);
            check("t1_falling_edge", o_falling_edge_busy, (k == 19) ? 1 : 0);
        end
        repeat (3) tick();

        // Level-held request sends one frame; data changes while busy are ignored
        t = cyc;
        i_valid = 1'b1;
        i_sideband_message = 4'h7;
        i_sideband_data_lanes_encoding = 3'b001;
        push_tx(16'hA720, t + 1);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i == 4) i_sideband_message = 4'hF;
            if (i == 10) i_sideband_message = 4'h7;
        end
        i_valid = 1'b0;
        tick();
        i_valid = 1'b1;
        t = cyc;
        push_tx(16'hA720, t + 1);
        repeat (25) tick();
        i_valid = 1'b0;
        tick();

        // Code 0 is ignored without consuming the arm; odd parity frame A101
        i_valid = 1'b1;
        i_sideband_message = 4'h0;
        i_sideband_data_lanes_encoding = 3'b000;
        repeat (3) tick();
        check("code0_no_busy", o_busy, 0);
        i_sideband_message = 4'h1;
        t = cyc;
        push_tx(16'hA101, t + 1);
        repeat (22) tick();
        i_valid = 1'b0;
        repeat (2) tick();

        // RX back-to-back good frames
        rxq.push_back({1'b0, 4'h5, 3'b011});
        rxq.push_back({1'b0, 4'h7, 3'b001});
        rx_bits(16'hA560, 16);
        rx_bits(16'hA720, 16);
        rx_idle();
        repeat (3) tick();

        // RX bad parity, bad preamble: errors, previous values held
        rxq.push_back({1'b1, 4'h7, 3'b001});
        rxq.push_back({1'b1, 4'h7, 3'b001});
        rx_bits(16'hA561, 16);
        rx_bits(16'hB560, 16);
        rx_idle();
        repeat (3) tick();

        // RX abort after 9 bits, then a clean frame
        rxq.push_back({1'b1, 4'h7, 3'b001});
        rx_bits(16'hA560, 9);
        rx_idle();
        repeat (3) tick();
        rxq.push_back({1'b0, 4'h5, 3'b011});
        rx_bits(16'hA560, 16);
        rx_idle();
        repeat (3) tick();

        // Reset during TX bit 8 with RX mid-frame
        f6 = 16'hA720;
        i_valid = 1'b1;
        i_sideband_message = 4'h5;
        i_sideband_data_lanes_encoding = 3'b011;
        i_sb_valid = 1'b1;
        i_sb_data = f6[15];
        for (int k = 1; k <= 7; k++) begin
            tick();
            i_sb_data = f6[15 - k];
        end
        tick();
        rst = 1'b1;
        rx_idle();
        tick();
        rst = 1'b0;
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_feb", o_falling_edge_busy, 0);
        check("mid_rst_sb", {o_sb_valid, o_sb_data}, 0);
        check("mid_rst_rx_msg", o_rx_msg, 0);
        check("mid_rst_rx_lanes", o_rx_lanes, 0);
        check("mid_rst_rx_flags", {o_rx_msg_valid, o_rx_err}, 0);
        t = cyc;
        push_tx(16'hA560, t + 1);
        rxq.push_back({1'b0, 4'h3, 3'b110});
        rx_bits(16'hA3C0, 16);
        rx_idle();
        repeat (10) tick();
        i_valid = 1'b0;
        repeat (10) tick();

        check("tx_queue_drained", txq_frame.size(), 0);
        check("rx_queue_drained", rxq.size(), 0);
        check("falling_edge_count", feb_seen, exp_feb);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/sb_msg_frame_agent.md
Name: sb_msg_frame_agent

Overview:
- Sideband message agent between the MBTRAIN substate blocks (repair and similar) and the serial sideband link. Both directions live in this block.
- TX path: accepts a message request (valid, 4-bit message code, 3-bit data-lanes encoding), serializes it as a 16-bit frame and drives busy. When the frame is done it pulses a falling-edge-of-busy strobe.
- RX path: deserializes incoming frames, checks them, and presents the message code, lanes encoding and a valid pulse to the substate blocks.

Parameters:
GAP_CYCLES, 2, idle cycles after the last frame bit before busy deasserts (legal range 0..15)
PREAMBLE, 4'hA, value carried in frame bits [15:12]

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_valid  in  1  TX message request, level; OR of substate valids
i_sideband_message  in  4  TX message code; 4'h0 = no message
i_sideband_data_lanes_encoding  in  3  TX lanes encoding
o_busy  out  1  TX frame in progress
o_falling_edge_busy  out  1  one-cycle pulse in the cycle o_busy returns low
o_sb_data  out  1  serial TX bit, MSB first
o_sb_valid  out  1  qualifies o_sb_data
i_sb_data  in  1  serial RX bit
i_sb_valid  in  1  qualifies i_sb_data
o_rx_msg  out  4  last good received message code
o_rx_lanes  out  3  last good received lanes encoding
o_rx_msg_valid  out  1  one-cycle pulse per good frame
o_rx_err  out  1  one-cycle pulse per discarded frame

Behaviour:
- Frame format, bit 15 sent first:
  - [15:12] = PREAMBLE
  - [11:8] = message code
  - [7:5] = lanes encoding
  - [4:1] = 4'b0000
  - [0] = parity bit chosen so that XOR of bits [11:0] = 0 (even parity over [11:1])
- Reset: all outputs 0 the cycle after rst is sampled high. o_rx_msg and o_rx_lanes clear to 0, all counters and shift registers clear, the TX arm flag is set to 1. Reset mid-frame aborts both paths immediately, with no pulses issued.
- TX FSM states: IDLE, SEND, GAP, DONE.
  - IDLE: if i_valid=1, arm=1 and i_sideband_message!=0 in cycle T, latch the frame, clear arm and go to SEND. A request with code 0 is ignored and does not clear arm.
  - SEND: o_busy=1 and o_sb_valid=1 during cycles T+1..T+16, shifting frame bit 15 down to bit 0. Then go to GAP if GAP_CYCLES>0, otherwise to DONE.
  - GAP: o_busy=1 and o_sb_valid=0 during cycles T+17..T+16+GAP_CYCLES.
  - DONE: lasts one cycle, T+17+GAP_CYCLES, with o_busy=0 and o_falling_edge_busy=1; then return to IDLE.
  - Earliest next capture is in DONE + 1.
- Arm flag: set again in any cycle where i_valid=0. A level-held i_valid therefore sends exactly one frame; a new request needs i_valid low for at least 1 cycle. While o_busy=1, i_valid and data changes are ignored (no queue).
- o_sb_data = 0 whenever o_sb_valid = 0.
- RX: a 16-bit shift register and a 4-bit counter advance only on cycles where i_sb_valid=1.
  - On the 16th valid bit (frame checked on the cycle after that bit is sampled):
    - If the preamble, reserved bits and parity all check, update o_rx_msg and o_rx_lanes and pulse o_rx_msg_valid.
    - Otherwise pulse o_rx_err and hold o_rx_msg and o_rx_lanes.
  - The counter then resets to 0, so back-to-back frames are accepted with no gap.
  - i_sb_valid low with counter != 0 aborts the frame: counter returns to 0 and o_rx_err pulses the next cycle. i_sb_valid low with counter 0 is idle.
  - RX and TX are independent and may run simultaneously; a TX frame has no effect on RX state.
- o_rx_msg_valid and o_rx_err are never high in the same cycle.

Test Plan:
- Reset, then i_valid=1 with msg 4'h5, lanes 3'b011 in cycle T -> o_sb_data carries 16'hA560 MSB first on T+1..T+16; o_busy high T+1..T+18; o_falling_edge_busy pulses at T+19 (GAP_CYCLES=2).
- Hold i_valid=1 for 60 cycles with msg 4'h7, lanes 3'b001 -> exactly one frame 16'hA720 is sent. Drop i_valid 1 cycle and raise it again -> a second A720 frame starts the cycle after the rising sample.
- Drive RX with 16'hA560 then 16'hA720 back-to-back (32 valid cycles) -> two o_rx_msg_valid pulses, with o_rx_msg = 5 then 7 and o_rx_lanes = 3 then 1.
- Drive RX with 16'hA561 (bad parity), then 16'hB560 (bad preamble) -> two o_rx_err pulses; o_rx_msg and o_rx_lanes hold their previous values.
- Drive RX with 9 valid bits of a frame, then drop i_sb_valid -> o_rx_err pulses. A following full 16'hA560 frame decodes correctly.
- Assert rst at TX bit 8 while RX is mid-frame -> all outputs 0 next cycle, no falling-edge pulse; i_valid still high after reset sends a fresh frame.
